// File: rtl/fib_seq_gen_pkg.sv
// Shared types and default sizing for the Fibonacci sequence generator.
package fib_seq_gen_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/fib_seq_gen_rca_n.sv
// WIDTH-bit ripple-carry adder; carry-out exported so the caller can flag overflow.
module rca_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];
endmodule

// File: rtl/fib_seq_gen.sv
// Streams n_terms Fibonacci-style terms from two seeds over a valid/ready port.
// Define FIB_SAT_EN to saturate sums at all-ones instead of wrapping.
module fib_seq_gen
    import fib_seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [CNT_W-1:0] n_terms,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             overflow
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, cur, sum, next_term;
    logic [CNT_W-1:0] remaining;
    logic             carry, accept, xfer, last_term;

    assign accept    = (state == IDLE) && start && (n_terms != '0);
    assign xfer      = (state == RUN) && out_ready;
    assign last_term = (remaining == CNT_W'(1));

    rca_n #(.WIDTH(WIDTH)) u_add (
        .a    (prev),
        .b    (cur),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

`ifdef FIB_SAT_EN
    assign next_term = carry ? '1 : sum;
`else
    assign next_term = sum;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)            state_nxt = RUN;
            RUN:  if (xfer && last_term) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        out_valid = busy;
        out_data  = busy ? prev : '0;
        out_last  = busy && last_term;
    end

    // Only a carry into a term that will still be emitted (remaining>=3) counts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev      <= '0;
            cur       <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            prev      <= seed0;
            cur       <= seed1;
            remaining <= n_terms;
            overflow  <= 1'b0;
        end else if (xfer) begin
            prev      <= cur;
            cur       <= next_term;
            remaining <= remaining - CNT_W'(1);
            if (carry && remaining >= CNT_W'(3)) overflow <= 1'b1;
        end
    end
endmodule

// File: doc/fib_seq_gen.md
FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data width of terms and seeds (minimum 2).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the term-count input.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, a request to begin a sequence; sampled only when busy=0.
REQ-006 SHALL have port seed0, input, WIDTH, the first term of the sequence.
REQ-007 SHALL have port seed1, input, WIDTH, the second term of the sequence.
REQ-008 SHALL have port n_terms, input, CNT_W, the number of terms to emit; sampled with start.
REQ-009 SHALL have port out_valid, output, 1, which is high when out_data holds a term.
REQ-010 SHALL have port out_ready, input, 1, the consumer accept; transfer when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, WIDTH, the current term.
REQ-012 SHALL have port out_last, output, 1, which is high with the final term of the sequence.
REQ-013 SHALL have port busy, output, 1, which is high while a sequence is in progress.
REQ-014 SHALL have port overflow, output, 1, a sticky flag set when an emitted term exceeds WIDTH bits.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; busy=1 iff state is RUN.
REQ-016 In IDLE, start=1 with n_terms!=0 SHALL load prev<=seed0, cur<=seed1, remaining<=n_terms, clear overflow, and enter RUN.
REQ-017 In IDLE, start=1 with n_terms=0 SHALL be ignored (no state change; overflow keeps its value).
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 In RUN, the block SHALL drive out_valid=1, out_data=prev, and out_last=(remaining==1).
REQ-020 The first term SHALL appear the cycle after start is accepted (latency 1); with out_ready held high, one term SHALL transfer per cycle.
REQ-021 On each transfer, the block SHALL update prev<=cur, cur<=sum(prev,cur), and remaining<=remaining-1.
REQ-022 On a transfer with remaining==1, the block SHALL return to IDLE, with out_valid=0 in the following cycle.
REQ-023 With out_valid=1 and out_ready=0, out_data, out_last and all internal state SHALL remain stable.
REQ-024 On a transfer with remaining>=3 and the adder carry-out=1, the block SHALL set overflow (only terms that will be emitted count); overflow SHALL hold until the next accepted start or reset.
REQ-025 The default sum SHALL be modulo 2^WIDTH (wrap).
REQ-026 In IDLE, out_valid, out_last and out_data SHALL be 0.

Reset
REQ-027 When reset=0 at a rising clk edge, the block SHALL enter IDLE and clear prev, cur, remaining, out_valid, out_last, busy and overflow to 0, regardless of the current state, including mid-sequence.
REQ-028 The first start SHALL be accepted in the first cycle after reset deasserts.

Configuration
REQ-029 When macro FIB_SAT_EN is defined, a sum with carry-out=1 SHALL be replaced by all-ones (2^WIDTH-1) and overflow SHALL still be set per REQ-024.
REQ-030 When FIB_SAT_EN is undefined, sums SHALL wrap per REQ-025 and the saturation logic SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, RUN) and the default WIDTH/CNT_W constants.
REQ-032 The addition SHALL use one sub-module, rca_n, a WIDTH-parametrised ripple-carry adder with carry-in tied to 0 and carry-out exported for overflow detection.
REQ-033 No behavioural "+" SHALL be used on the term path.

Verification (WIDTH=8)
REQ-034 Test 1: seed0=0, seed1=1, n_terms=14, out_ready=1 -> outputs 0,1,1,2,3,5,8,13,21,34,55,89,144,233; out_last only on 233; overflow=0.
REQ-035 Test 2: same seeds, n_terms=15 -> 15th term 121 (377 mod 256); overflow=1 after the 13th transfer. With FIB_SAT_EN, the 15th term is 255.
REQ-036 Test 3: out_ready toggled 1,0,0,1,... during Test 1 -> the identical 14-term sequence, with out_data stable while stalled.
REQ-037 Test 4: start pulsed mid-sequence with new seeds (5,5) -> ignored; the original sequence completes unchanged.
REQ-038 Test 5: reset=0 for one cycle after the 6th term -> next cycle out_valid=0, busy=0, overflow=0; a new start with seeds (2,3), n_terms=4 gives 2,3,5,8.
REQ-039 Test 6: start with n_terms=0 -> busy stays 0 and no out_valid; n_terms=1 with seed0=7 -> single term 7 with out_last=1.
